muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle RV32M controller: iterative shift-add multiplier / restoring divider behind the ALU.
//  Accepts R_TYPE ops with Funct7_0=1, stalls the fetch/decode pipeline while iterating, returns one 32-bit result.
//  Sits beside ALU_Control: that block keeps M-ops off the single-cycle ALU; this block owns them.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  6   iteration counter width (holds XLEN-1 down to 0)
// PORTS
//  CLK           in   1     single clock, rising edge
//  rst_n         in   1     asynchronous, active-low reset
//  start         in   1     decoded instruction valid this cycle
//  opcode        in   7     instruction opcode
//  Funct3        in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  Funct7_0      in   1     M-extension select bit
//  rs1, rs2      in   XLEN  operands, sampled only in the accept cycle
//  flush         in   1     synchronous abort (branch redirect / trap)
//  stall         out  1     hold PC and decode stage
//  busy          out  1     state != IDLE
//  result        out  XLEN  registered result, held until the next result_valid
//  result_valid  out  1     one-cycle pulse, result valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, counter=0, result=0, result_valid=0, busy=0; stall=0.
//  Accept: state==IDLE && start && opcode==7'b0110011 && Funct7_0 && !flush. Latch Funct3, rs1, rs2.
//   Otherwise start is ignored: non-M op, busy, or DONE cycle.
//  FSM: IDLE->PREP->CALC(XLEN cycles)->FIX->DONE->IDLE. Special-case divide: IDLE->DONE.
//  Latency, accept cycle = 0: PREP c1, CALC c2..c33, FIX c34, DONE c35 (result_valid=1). Special case: DONE c1.
//  stall = (IDLE && accept) || state in {PREP,CALC,FIX}. stall is low in DONE, so the pipeline advances with result.
//  PREP: compute magnitudes of signed operands; record neg = sign(a)^sign(b) (product/quotient).
//   Record rneg = sign(a) (remainder). MULHSU: only rs1 is signed. MULHU/DIVU/REMU: no signs.
//  CALC mult: per cycle, if multiplier LSB then hi += mcand (XLEN+1 bit carry); shift {hi,lo} right 1.
//  CALC div: per cycle, shift {rem,quo} left 1; trial = rem - divisor; if trial >= 0 then rem=trial, quo LSB=1.
//  Counter loads XLEN-1 in PREP and decrements in CALC; CALC exits when counter==0.
//  FIX: 2's-complement negate the 2*XLEN product if neg; MUL selects lo, MULH* select hi.
//   Negate quotient if neg, remainder if rneg; DIV* select quotient, REM* select remainder.
//  Divide by zero (rs2==0): quotient=all ones, remainder=rs1, no trap.
//  Overflow (DIV/REM, rs1=0x8000_0000, rs2=0xFFFF_FFFF): quotient=0x8000_0000, remainder=0.
//  Arithmetic is modulo 2^XLEN. No exceptions are raised.
//  flush in any non-IDLE state: IDLE on the next edge, no result_valid, result unchanged. flush beats start.
//  flush in DONE: result_valid still pulses that cycle. Already committed; the pipeline must discard it.
//  rst_n low mid-operation: immediate abort to reset values; operation is lost.
// STRUCTURE
//  Package rv32i_pkg: R_TYPE opcode, Funct3 M-op constants, FSM state encoding (3-bit), XLEN.
//  One sub-module: muldiv_iter_core. Holds the datapath: operand/acc/quotient registers, adder/subtractor,
//   one-step shift, final negation, driven by op/step/load/fix strobes.
//  muldiv_sequencer keeps the FSM, counter, accept/stall/flush logic and special-case detection.
// TESTING
//  MUL rs1=7 rs2=0xFFFF_FFFD accepted c0 -> result=0xFFFF_FFEB, result_valid only at c35; stall=1 c0..c34.
//  rs1=rs2=0xFFFF_FFFF: MULHU -> 0xFFFF_FFFE; MULH -> 0x0000_0000; MULHSU -> 0xFFFF_FFFF; MUL -> 0x0000_0001.
//  rs1=0xFFFF_FFF9 (-7), rs2=2: DIV -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF. rs1=100 rs2=7: DIVU -> 14, REMU -> 2.
//  DIV 5/0 -> 0xFFFF_FFFF, REM 5/0 -> 5, each valid at c1. DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000; REM -> 0.
//  DIVU start, flush at c10 -> busy=0 at c11, no result_valid, result unchanged; new MUL accepted at c12 -> valid at c47.
//   rst_n=0 at c20 -> outputs reset the same cycle.
//  Ignored starts: Funct7_0=0 (ADD), start during CALC, start in DONE -> no state change.
//   Back-to-back: accepted at c36, valid at c71.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rv32i_pkg : shared RV32 constants for the M-extension sequencer    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package rv32i_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_iter_core : shift-add multiply / restoring divide datapath  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_iter_core
  import rv32i_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            special_i,
  input  logic            prep_i,
  input  logic            step_i,
  input  logic            fix_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [XLEN-1:0] result_o
);

  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] m_q, m_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic [XLEN:0]   w_add;
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_diff;
  logic [2*XLEN-1:0] w_prod, w_prod_fix;
  logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_spec_res;

  assign w_is_div   = op_q[2];
  assign w_a_signed = (op_q == F3_MULH) || (op_q == F3_MULHSU) ||
                      (op_q == F3_DIV)  || (op_q == F3_REM);
  assign w_b_signed = (op_q == F3_MULH) || (op_q == F3_DIV) || (op_q == F3_REM);
  assign w_a_neg    = w_a_signed & a_q[XLEN-1];
  assign w_b_neg    = w_b_signed & b_q[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a_q : a_q;
  assign w_b_mag    = w_b_neg ? -b_q : b_q;

  assign w_add   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(XLEN+1){1'b0}});
  assign w_shift = {hi_q, lo_q[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, m_q});
  // Partial remainder stays below the divisor, so the difference fits XLEN bits.
  assign w_diff  = w_shift[XLEN-1:0] - m_q;

  assign w_prod     = {hi_q, lo_q};
  assign w_prod_fix = neg_q  ? -w_prod : w_prod;
  assign w_quo_fix  = neg_q  ? -lo_q   : lo_q;
  assign w_rem_fix  = rneg_q ? -hi_q   : hi_q;

  // Divide by zero or signed overflow, resolved straight from the operands.
  assign w_spec_res = (rs2_i == '0) ? (funct3_i[1] ? rs1_i : '1)
                                    : (funct3_i[1] ? '0    : rs1_i);

  always_comb begin
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    m_d    = m_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    res_d  = res_q;
    if (load_i) begin
      op_d = funct3_i;
      a_d  = rs1_i;
      b_d  = rs2_i;
      if (special_i) res_d = w_spec_res;
    end
    if (prep_i) begin
      hi_d   = '0;
      neg_d  = w_a_neg ^ w_b_neg;
      rneg_d = w_a_neg;
      if (w_is_div) begin
        m_d  = w_b_mag;
        lo_d = w_a_mag;
      end else begin
        m_d  = w_a_mag;
        lo_d = w_b_mag;
      end
    end
    if (step_i) begin
      if (w_is_div) begin
        hi_d = w_ge ? w_diff : w_shift[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], w_ge};
      end else begin
        hi_d = w_add[XLEN:1];
        lo_d = {w_add[0], lo_q[XLEN-1:1]};
      end
    end
    if (fix_i) begin
      if (w_is_div)
        res_d = op_q[1] ? w_rem_fix : w_quo_fix;
      else if (op_q == F3_MUL)
        res_d = w_prod_fix[XLEN-1:0];
      else
        res_d = w_prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      res_q  <= '0;
    end else begin
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      m_q    <= m_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      res_q  <= res_d;
    end
  end

  assign result_o = res_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_sequencer : RV32M multi-cycle controller with pipeline stall|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module muldiv_sequencer
  import rv32i_pkg::*;
(
  input  logic            CLK,
  input  logic            rst_n,
  input  logic            start,
  input  logic [6:0]      opcode,
  input  logic [2:0]      Funct3,
  input  logic            Funct7_0,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_accept, w_special;
  logic             w_load, w_spec_load, w_prep, w_step, w_fix;

  assign w_accept  = (state_q == S_IDLE) && start && (opcode == OPC_R_TYPE) &&
                     Funct7_0 && !flush;
  assign w_special = Funct3[2] &&
                     ((rs2 == '0) ||
                      (!Funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1)));

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (w_accept) state_d = w_special ? S_DONE : S_PREP;
      S_PREP: begin
        state_d = S_CALC;
        cnt_d   = CNT_W'(XLEN-1);
      end
      S_CALC: begin
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath strobes are masked by flush so an aborted op never touches result.
  always_comb begin
    busy         = (state_q != S_IDLE);
    stall        = ((state_q == S_IDLE) && w_accept) || (state_q == S_PREP) ||
                   (state_q == S_CALC) || (state_q == S_FIX);
    result_valid = (state_q == S_DONE);
    w_load       = w_accept;
    w_spec_load  = w_accept && w_special;
    w_prep       = (state_q == S_PREP) && !flush;
    w_step       = (state_q == S_CALC) && !flush;
    w_fix        = (state_q == S_FIX)  && !flush;
  end

  muldiv_iter_core u_core (
    .clk_i     (CLK),
    .rst_ni    (rst_n),
    .load_i    (w_load),
    .special_i (w_spec_load),
    .prep_i    (w_prep),
    .step_i    (w_step),
    .fix_i     (w_fix),
    .funct3_i  (Funct3),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .result_o  (result)
  );

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_muldiv_sequencer : directed scoreboard bench for the sequencer  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic [2:0]  Funct3;
  logic        Funct7_0;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        stall, busy, result_valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_exp = 32'h0;

  muldiv_sequencer dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .start        (start),
    .opcode       (opcode),
    .Funct3       (Funct3),
    .Funct7_0     (Funct7_0),
    .rs1          (rs1),
    .rs2          (rs2),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got result %h with no pending op (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("valid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    opcode   = 7'b0110011;
    Funct7_0 = 1'b1;
    Funct3   = f3;
    rs1      = a;
    rs2      = b;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    drive(f3, a, b);
    if (push) sb_q.push_back('{exp, cyc + lat});
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      tick();
    end
    check("drain_pending", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    issue(f3, a, b, exp, lat, 1'b1);
    drain();
    last_exp = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    rst_n = 1'b0; start = 1'b0; opcode = '0; Funct3 = '0; Funct7_0 = 1'b0;
    rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (3) tick();
    check("reset_result", result, 32'h0);
    check("reset_flags", {29'd0, busy, stall, result_valid}, 32'd0);
    rst_n = 1'b1;
    tick();

    // MUL 7 * -3 with full stall-window check
    drive(3'b000, 32'd7, 32'hFFFF_FFFD);
    sb_q.push_back('{32'hFFFF_FFEB, cyc + 35});
    @(negedge CLK);
    check("stall_c0", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    bad = 0;
    for (int k = 1; k <= 35; k++) begin
      @(negedge CLK);
      if (stall !== (k <= 34)) bad++;
      if (busy !== 1'b1) bad++;
      tick();
    end
    check("stall_busy_window", 32'(bad), 32'd0);
    drain();
    last_exp = 32'hFFFF_FFEB;

    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35);
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 35);
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 35);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h10, 32'hF, 35);
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(3'b110, 32'd5, 32'd0, 32'd5, 1);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // Flush during CALC, then a fresh MUL accepted two cycles later
    issue(3'b101, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_result_held", result, last_exp);
    tick();
    run_op(3'b000, 32'h1234, 32'h10, 32'h0001_2340, 35);

    // Ignored starts: plain ADD (Funct7_0=0) and an I-type opcode
    drive(3'b000, 32'd1, 32'd2);
    Funct7_0 = 1'b0;
    @(negedge CLK);
    check("add_stall", {31'd0, stall}, 32'd0);
    tick();
    check("add_busy", {31'd0, busy}, 32'd0);
    drive(3'b000, 32'd1, 32'd2);
    opcode = 7'b0010011;
    tick();
    start = 1'b0;
    check("itype_busy", {31'd0, busy}, 32'd0);

    // start held through CALC and DONE; only c0 and c36 accept
    drive(3'b000, 32'd6, 32'd7);
    sb_q.push_back('{32'd42, cyc + 35});
    for (int k = 1; k <= 36; k++) begin
      tick();
      if (k == 35) begin
        @(negedge CLK);
        check("stall_done_start", {31'd0, stall}, 32'd0);
      end
    end
    drive(3'b101, 32'd1000, 32'd10);
    sb_q.push_back('{32'd100, cyc + 35});
    @(negedge CLK);
    check("b2b_accept_stall", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    drain();
    last_exp = 32'd100;

    // Asynchronous reset mid-operation
    issue(3'b000, 32'd3, 32'd3, 32'd9, 35, 1'b0);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 32'h0);
    check("async_rst_flags", {29'd0, busy, stall, result_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
